fir_stream_driver: RTL and testbench
====================================

Name: fir_stream_driver

Overview:
- Hardware driver for the fir_filter load/stream interface; replaces the bench-only sequencing of coefficients and samples.
- Accepts coefficients and samples on valid/ready streams. Drives load_c, coef_in and data_in with the exact cycle protocol the filter expects.
- Re-aligns data_out into a valid-tagged output stream.
- Sits between the system stream fabric and fir_filter.

Parameters:
- N_COEF, 25, number of taps; coefficient load lasts exactly N_COEF cycles
- COEF_W, 16, coefficient width
- DATA_W, 8, sample width
- DOUT_W, 15, filter output width
- LAT, 2, filter latency in cycles from data_in to the corresponding data_out
- LEN_W, 20, width of frame length counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins coefficient load, then frame
- frame_len  in  LEN_W  sample count for the frame; sampled on start; 0 is illegal and is treated as 1
- c_valid  in  1  coefficient stream valid
- c_data  in  COEF_W  coefficient word, tap 0 first
- c_ready  out  1  coefficient accepted when c_valid&&c_ready
- s_valid  in  1  sample stream valid
- s_data  in  DATA_W  sample
- s_ready  out  1  sample accepted when s_valid&&s_ready
- load_c  out  1  to filter: coefficient load strobe
- coef_in  out  COEF_W  to filter
- data_in  out  DATA_W  to filter
- fir_out  in  DOUT_W  from filter data_out
- m_valid  out  1  output sample valid
- m_data  out  DOUT_W  output sample
- busy  out  1  high in any state other than IDLE
- underrun  out  1  sticky; set when a zero bubble was inserted; cleared on start

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge) takes effect from any state, including mid-load and mid-frame:
  - State goes to IDLE; all counters go to 0.
  - load_c, coef_in, data_in, c_ready, s_ready, m_valid, m_data, busy and underrun all go to 0.
  - The LAT valid pipeline is flushed.
- IDLE:
  - c_ready=0, s_ready=0, load_c=0, data_in=0.
  - On start: latch frame_len, clear underrun, go to LOAD.
- LOAD:
  - c_ready=1.
  - Each accepted coefficient is registered onto coef_in with load_c=1 in the following cycle.
  - Cycles with no accept drive load_c=0 and hold coef_in. The filter only shifts on load_c=1, so gaps are legal.
  - After N_COEF accepts, the next cycle drives load_c=0, coef_in=0, and the state goes to STREAM.
  - start is ignored outside IDLE.
- STREAM:
  - s_ready=1 every cycle. The filter consumes one sample per clock and has no stall.
  - Accepted sample: data_in=s_data in the next cycle, valid bit 1 enters the LAT pipeline, sample count increments.
  - No s_valid: data_in=0 (bubble), valid bit 0 enters the pipeline, underrun=1.
  - When the count reaches frame_len, the state goes to DRAIN and s_ready drops in the same cycle as the last accept.
- DRAIN:
  - data_in=0 for N_COEF-1 cycles to flush the filter history; these bubbles do not set underrun.
  - Drain inputs enter the pipeline with valid bit 1, so m_valid asserts for the N_COEF-1 tail outputs.
  - Then wait LAT cycles for the pipeline to empty and return to IDLE.
- Output alignment:
  - m_valid and m_data are registered from the LAT-deep valid shift register and fir_out.
  - First m_valid occurs exactly LAT+1 cycles after the cycle data_in carries the first sample.
  - Total m_valid pulses per frame = frame_len + N_COEF - 1.
- Counter widths:
  - Coefficient counter is ceil(log2(N_COEF+1)) bits; sample counter is LEN_W bits.
  - No wrap-around is possible because frame_len is bounded by LEN_W.
- busy rises the cycle after start and falls on entry to IDLE.

Decomposition:
- Shared package fir_pkg:
  - state enum {IDLE, LOAD, STREAM, DRAIN}
  - default widths COEF_W, DATA_W, DOUT_W and N_COEF
  - a clog2-based counter width constant
- One natural sub-module: fir_valid_delay, a parameterised LAT-deep shift register of valid bits with synchronous flush.

Test Plan:
- Reset then start with frame_len=4:
  - Coefficients 1..25 offered back-to-back -> exactly 25 load_c pulses with coef_in=1..25 in order.
  - Samples 10,20,30,40 offered back-to-back -> data_in=10,20,30,40, then 24 zeros.
  - 28 m_valid pulses; the first appears LAT+1 cycles after data_in=10.
- Coefficient gaps: c_valid toggled every other cycle -> load_c has 25 pulses with gaps; coef_in holds between pulses; STREAM is entered only after the 25th.
- Sample underrun: s_valid low for 3 cycles mid-frame -> data_in=0 for those 3 cycles, underrun=1 and sticky, m_valid low for the 3 matching output cycles.
- Reset mid-LOAD after 10 coefficients -> next cycle load_c=0, busy=0, c_ready=0; a new start performs a full 25-coefficient load.
- start asserted while busy -> ignored, with no change to the count or sequence; frame_len=0 -> behaves as frame_len=1 (1+24 m_valid pulses).

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the fir_filter stream driver: the driver state
// encoding, default widths of the filter interface, and the helper used to
// size the coefficient counter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } fir_state_e;

  localparam int FIR_N_COEF = 25;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_DATA_W = 8;
  localparam int FIR_DOUT_W = 15;
  localparam int FIR_LAT    = 2;
  localparam int FIR_LEN_W  = 20;

  // Bits needed to hold the value n itself (count of 0..n inclusive).
  function automatic int fir_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int FIR_CCNT_W = fir_cnt_w(FIR_N_COEF);

endpackage

// File: rtl/fir_valid_delay.sv
// fir_valid_delay
// LAT-deep shift register of valid bits. A bit entering alongside data_in
// leaves in the cycle the filter presents the matching data_out.
// Ports:
//   clk     clock
//   i_flush synchronous clear of every stage
//   i_vld   valid bit aligned with data_in
//   o_vld   valid bit aligned with fir_out (LAT cycles later)
module fir_valid_delay
  import fir_pkg::*;
#(
  parameter int LAT = FIR_LAT
) (
  input  logic clk,
  input  logic i_flush,
  input  logic i_vld,
  output logic o_vld
);

  generate
    if (LAT == 0) begin : g_pass
      assign o_vld = i_vld;
    end else begin : g_sr
      logic [LAT-1:0] r_vld_p;

      always_ff @(posedge clk) begin
        if (i_flush) begin
          r_vld_p <= '0;
        end else begin
          r_vld_p[0] <= i_vld;
          for (int i = 1; i < LAT; i++) begin
            r_vld_p[i] <= r_vld_p[i-1];
          end
        end
      end

      assign o_vld = r_vld_p[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/fir_stream_driver.sv
// fir_stream_driver
// Sequences a fir_filter from valid/ready streams: loads N_COEF coefficients
// through load_c/coef_in, feeds one sample per clock on data_in (zero bubbles
// when the source runs dry), flushes the filter history with N_COEF-1 zeros,
// and re-tags fir_out as a valid-qualified output stream.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, frame_len    frame kick-off pulse and sample count (0 means 1)
//   c_valid/c_data/c_ready  coefficient stream, tap 0 first
//   s_valid/s_data/s_ready  sample stream
//   load_c, coef_in, data_in  to the filter
//   fir_out             filter data_out
//   m_valid, m_data     re-aligned output stream
//   busy, underrun      status (underrun is sticky until the next start)
module fir_stream_driver
  import fir_pkg::*;
#(
  parameter int N_COEF = FIR_N_COEF,
  parameter int COEF_W = FIR_COEF_W,
  parameter int DATA_W = FIR_DATA_W,
  parameter int DOUT_W = FIR_DOUT_W,
  parameter int LAT    = FIR_LAT,
  parameter int LEN_W  = FIR_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              c_valid,
  input  logic [COEF_W-1:0] c_data,
  output logic              c_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              load_c,
  output logic [COEF_W-1:0] coef_in,
  output logic [DATA_W-1:0] data_in,
  input  logic [DOUT_W-1:0] fir_out,
  output logic              m_valid,
  output logic [DOUT_W-1:0] m_data,
  output logic              busy,
  output logic              underrun
);

  localparam int CCNT_W = fir_cnt_w(N_COEF);
  localparam logic [CCNT_W-1:0] C_LAST = CCNT_W'(N_COEF - 1);
  localparam logic [CCNT_W-1:0] C_FULL = CCNT_W'(N_COEF);
  // Drain: N_COEF-1 valid zeros, then LAT cycles for the pipeline to empty.
  localparam logic [LEN_W-1:0]  D_TAIL = LEN_W'(N_COEF - 1);
  localparam logic [LEN_W-1:0]  D_LAST = LEN_W'(N_COEF - 2 + LAT);

  fir_state_e          r_state, w_state_nxt;
  logic [CCNT_W-1:0]   r_ccnt, w_ccnt_nxt;
  logic [LEN_W-1:0]    r_scnt, w_scnt_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic                r_c_ready, w_c_ready_nxt;
  logic                r_s_ready, w_s_ready_nxt;
  logic                r_load_c, w_load_c_nxt;
  logic [COEF_W-1:0]   r_coef, w_coef_nxt;
  logic [DATA_W-1:0]   r_din_p0, w_din_nxt;
  logic                r_vld_p0, w_vld_nxt;
  logic                r_underrun, w_underrun_nxt;
  logic                r_busy;
  logic                r_m_valid;
  logic [DOUT_W-1:0]   r_m_data;
  logic                w_vld_dly;
  logic                w_c_acc;
  logic                w_s_acc;

  assign w_c_acc = c_valid && r_c_ready;
  assign w_s_acc = s_valid && r_s_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ccnt_nxt     = r_ccnt;
    w_scnt_nxt     = r_scnt;
    w_len_nxt      = r_len;
    w_c_ready_nxt  = 1'b0;
    w_s_ready_nxt  = 1'b0;
    w_load_c_nxt   = 1'b0;
    w_coef_nxt     = r_coef;
    w_din_nxt      = '0;
    w_vld_nxt      = 1'b0;
    w_underrun_nxt = r_underrun;
    case (r_state)
      IDLE: begin
        w_coef_nxt = '0;
        if (start) begin
          w_len_nxt      = (frame_len == '0) ? LEN_W'(1) : frame_len;
          w_underrun_nxt = 1'b0;
          w_ccnt_nxt     = '0;
          w_c_ready_nxt  = 1'b1;
          w_state_nxt    = LOAD;
        end
      end
      LOAD: begin
        if (r_ccnt == C_FULL) begin
          // Last load_c pulse is on the wire now; park coef_in and start feeding.
          w_coef_nxt    = '0;
          w_scnt_nxt    = '0;
          w_s_ready_nxt = 1'b1;
          w_state_nxt   = STREAM;
        end else begin
          w_c_ready_nxt = 1'b1;
          if (w_c_acc) begin
            w_load_c_nxt = 1'b1;
            w_coef_nxt   = c_data;
            w_ccnt_nxt   = r_ccnt + CCNT_W'(1);
            if (r_ccnt == C_LAST) begin
              w_c_ready_nxt = 1'b0;
            end
          end
        end
      end
      STREAM: begin
        w_s_ready_nxt = 1'b1;
        if (w_s_acc) begin
          w_din_nxt  = s_data;
          w_vld_nxt  = 1'b1;
          w_scnt_nxt = r_scnt + LEN_W'(1);
          if ((r_scnt + LEN_W'(1)) == r_len) begin
            w_s_ready_nxt = 1'b0;
            w_scnt_nxt    = '0;
            w_state_nxt   = DRAIN;
          end
        end else begin
          // The filter cannot stall, so a missing sample becomes a zero bubble.
          w_underrun_nxt = 1'b1;
        end
      end
      DRAIN: begin
        w_vld_nxt  = (r_scnt < D_TAIL);
        w_scnt_nxt = r_scnt + LEN_W'(1);
        if (r_scnt == D_LAST) begin
          w_scnt_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---- stage p0: control state and filter-side drive registers ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ccnt     <= '0;
      r_scnt     <= '0;
      r_len      <= '0;
      r_c_ready  <= 1'b0;
      r_s_ready  <= 1'b0;
      r_load_c   <= 1'b0;
      r_coef     <= '0;
      r_din_p0   <= '0;
      r_vld_p0   <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ccnt     <= w_ccnt_nxt;
      r_scnt     <= w_scnt_nxt;
      r_len      <= w_len_nxt;
      r_c_ready  <= w_c_ready_nxt;
      r_s_ready  <= w_s_ready_nxt;
      r_load_c   <= w_load_c_nxt;
      r_coef     <= w_coef_nxt;
      r_din_p0   <= w_din_nxt;
      r_vld_p0   <= w_vld_nxt;
      r_underrun <= w_underrun_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  // ---- stages p1..pLAT: valid bits follow the filter latency ----
  fir_valid_delay #(
    .LAT (LAT)
  ) u_vld_dly (
    .clk     (clk),
    .i_flush (!reset),
    .i_vld   (r_vld_p0),
    .o_vld   (w_vld_dly)
  );

  // ---- output stage: re-tag fir_out ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_m_valid <= w_vld_dly;
      r_m_data  <= fir_out;
    end
  end

  assign c_ready  = r_c_ready;
  assign s_ready  = r_s_ready;
  assign load_c   = r_load_c;
  assign coef_in  = r_coef;
  assign data_in  = r_din_p0;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_fir_stream_driver.sv
// tb_fir_stream_driver
// Directed bench for fir_stream_driver. A stand-in filter returns data_in
// after LAT cycles with a fixed tag in the low bits so output alignment is
// observable. Outputs are sampled on the falling edge.
module tb_fir_stream_driver;
  localparam int N_COEF = 25;
  localparam int COEF_W = 16;
  localparam int DATA_W = 8;
  localparam int DOUT_W = 15;
  localparam int LAT    = 2;
  localparam int LEN_W  = 20;
  localparam logic [6:0] TAG = 7'h5A;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              c_valid = 1'b0;
  logic [COEF_W-1:0] c_data = '0;
  logic              c_ready;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              load_c;
  logic [COEF_W-1:0] coef_in;
  logic [DATA_W-1:0] data_in;
  logic [DOUT_W-1:0] fir_out;
  logic              m_valid;
  logic [DOUT_W-1:0] m_data;
  logic              busy;
  logic              underrun;

  always #5 clk = ~clk;

  fir_stream_driver #(
    .N_COEF(N_COEF), .COEF_W(COEF_W), .DATA_W(DATA_W),
    .DOUT_W(DOUT_W), .LAT(LAT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_c(load_c), .coef_in(coef_in), .data_in(data_in),
    .fir_out(fir_out), .m_valid(m_valid), .m_data(m_data),
    .busy(busy), .underrun(underrun)
  );

  // Stand-in filter: LAT=2 register delay of data_in.
  logic [7:0] d1 = '0;
  logic [7:0] d2 = '0;
  always @(posedge clk) begin
    d1 <= data_in;
    d2 <= d1;
  end
  assign fir_out = {d2, TAG};

  int checks = 0;
  int errors = 0;

  // Event logs filled on every falling edge while enabled.
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] lc_vals[$];
  int          lc_cyc[$];
  logic [7:0]  din_vals[$];
  int          din_cyc[$];
  int          mv_cyc[$];
  logic [14:0] mv_data[$];
  int          sr_first = -1;
  int          hold_bad = 0;
  bit          seen_lc = 1'b0;
  logic [15:0] last_coef = '0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      din_vals.push_back(data_in);
      din_cyc.push_back(cyc);
      if (load_c === 1'b1) begin
        lc_vals.push_back(coef_in);
        lc_cyc.push_back(cyc);
        last_coef = coef_in;
        seen_lc = 1'b1;
      end else if (seen_lc && lc_vals.size() < N_COEF && coef_in !== last_coef) begin
        hold_bad++;
      end
      if (m_valid === 1'b1) begin
        mv_cyc.push_back(cyc);
        mv_data.push_back(m_data);
      end
      if (s_ready === 1'b1 && sr_first < 0) sr_first = cyc;
    end
  end

  task automatic mon_clear();
    lc_vals.delete(); lc_cyc.delete();
    din_vals.delete(); din_cyc.delete();
    mv_cyc.delete(); mv_data.delete();
    sr_first = -1; hold_bad = 0; seen_lc = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    @(negedge clk); start = 1'b1; frame_len = len;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_coefs(input int first, input int last, input bit gap);
    int k = first;
    int t = 0;
    while (k <= last && t < 400) begin
      @(negedge clk); t++;
      c_valid = gap ? t[0] : 1'b1;
      c_data = 16'(k);
      if (c_valid && c_ready) k++;
    end
    @(negedge clk); c_valid = 1'b0;
  endtask

  task automatic drive_samples(input int n, input int base, input int step,
                               input int hole_at, input int hole_len);
    int k = 0;
    int t = 0;
    int holes = 0;
    while (k < n && t < 400) begin
      @(negedge clk); t++;
      if (k == hole_at && holes < hole_len) begin
        s_valid = 1'b0;
        if (s_ready) holes++;
      end else begin
        s_valid = 1'b1;
        s_data = 8'(base + step * k);
        if (s_ready) k++;
      end
    end
    @(negedge clk); s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy === 1'b1 && t < 300) begin
      @(negedge clk); t++;
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic int find_din(input logic [7:0] v);
    for (int i = 0; i < din_vals.size(); i++) if (din_vals[i] === v) return i;
    return -1;
  endfunction

  // Index of the first data_in entry (from i0) differing from exp, or -1.
  function automatic int din_mismatch(input int i0, input logic [7:0] exp[$]);
    if (i0 < 0) return 0;
    for (int j = 0; j < exp.size(); j++)
      if (i0 + j >= din_vals.size() || din_vals[i0 + j] !== exp[j]) return j;
    return -1;
  endfunction

  function automatic int coef_bad();
    int bad = 0;
    for (int i = 0; i < lc_vals.size(); i++) if (lc_vals[i] !== 16'(i + 1)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL rst_c_ready: got %0b want 0", c_ready); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0b want 0", s_ready); end
    checks++; if (load_c !== 1'b0) begin errors++; $display("FAIL rst_load_c: got %0b want 0", load_c); end
    checks++; if (coef_in !== 16'd0) begin errors++; $display("FAIL rst_coef_in: got %0h want 0", coef_in); end
    checks++; if (data_in !== 8'd0) begin errors++; $display("FAIL rst_data_in: got %0h want 0", data_in); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
    checks++; if (m_data !== 15'd0) begin errors++; $display("FAIL rst_m_data: got %0h want 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %0b want 0", underrun); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || c_ready !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%0b c_ready=%0b want 0,0", busy, c_ready); end
  endtask

  task automatic test_basic();
    int i0;
    int mm;
    logic [7:0] exp[$];
    mon_clear();
    do_start(20'd4);
    checks++; if (busy !== 1'b1 || c_ready !== 1'b1) begin errors++; $display("FAIL basic_after_start: busy=%0b c_ready=%0b want 1,1", busy, c_ready); end
    drive_coefs(1, 25, 1'b0);
    drive_samples(4, 10, 10, -1, 0);
    wait_idle();
    checks++; if (lc_vals.size() !== 25) begin errors++; $display("FAIL basic_load_pulses: got %0d want 25", lc_vals.size()); end
    checks++; if (coef_bad() !== 0) begin errors++; $display("FAIL basic_coef_order: %0d wrong values want 0", coef_bad()); end
    exp = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int j = 0; j < N_COEF - 1; j++) exp.push_back(8'd0);
    i0 = find_din(8'd10);
    mm = din_mismatch(i0, exp);
    checks++; if (i0 < 0 || mm >= 0) begin errors++; $display("FAIL basic_data_in_seq: first sample at %0d, mismatch at %0d want -1", i0, mm); end
    checks++; if (mv_cyc.size() !== 28) begin errors++; $display("FAIL basic_m_valid_count: got %0d want 28", mv_cyc.size()); end
    if (mv_cyc.size() > 0 && i0 >= 0) begin
      checks++; if (mv_cyc[0] - din_cyc[i0] !== LAT + 1) begin errors++; $display("FAIL basic_first_latency: got %0d want %0d", mv_cyc[0] - din_cyc[i0], LAT + 1); end
      checks++; if (mv_data[0] !== {8'd10, TAG}) begin errors++; $display("FAIL basic_first_m_data: got %0h want %0h", mv_data[0], {8'd10, TAG}); end
      checks++; if (mv_cyc[mv_cyc.size()-1] - mv_cyc[0] !== 27) begin errors++; $display("FAIL basic_m_valid_span: got %0d want 27", mv_cyc[mv_cyc.size()-1] - mv_cyc[0]); end
    end
    if (mv_data.size() > 3) begin
      checks++; if (mv_data[3] !== {8'd40, TAG}) begin errors++; $display("FAIL basic_fourth_m_data: got %0h want %0h", mv_data[3], {8'd40, TAG}); end
    end
    checks++; if (busy !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL basic_end_status: busy=%0b underrun=%0b want 0,0", busy, underrun); end
    checks++; if (load_c !== 1'b0 || coef_in !== 16'd0) begin errors++; $display("FAIL basic_end_coef: load_c=%0b coef_in=%0h want 0,0", load_c, coef_in); end
  endtask

  task automatic test_coef_gaps();
    int gaps_bad = 0;
    mon_clear();
    do_start(20'd2);
    drive_coefs(1, 25, 1'b1);
    drive_samples(2, 30, 1, -1, 0);
    wait_idle();
    checks++; if (lc_vals.size() !== 25) begin errors++; $display("FAIL gap_load_pulses: got %0d want 25", lc_vals.size()); end
    checks++; if (coef_bad() !== 0) begin errors++; $display("FAIL gap_coef_order: %0d wrong values want 0", coef_bad()); end
    for (int i = 1; i < lc_cyc.size(); i++) if (lc_cyc[i] - lc_cyc[i-1] !== 2) gaps_bad++;
    checks++; if (gaps_bad !== 0) begin errors++; $display("FAIL gap_pulse_spacing: %0d spacings differ from 2 want 0", gaps_bad); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL gap_coef_hold: %0d cycles changed want 0", hold_bad); end
    if (lc_cyc.size() > 0) begin
      checks++; if (sr_first <= lc_cyc[lc_cyc.size()-1]) begin errors++; $display("FAIL gap_stream_after_load: s_ready at %0d, last load_c at %0d", sr_first, lc_cyc[lc_cyc.size()-1]); end
    end
    checks++; if (mv_cyc.size() !== 26) begin errors++; $display("FAIL gap_m_valid_count: got %0d want 26", mv_cyc.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_end_busy: got %0b want 0", busy); end
  endtask

  task automatic test_underrun();
    int i0;
    int mm;
    logic [7:0] exp[$];
    mon_clear();
    do_start(20'd6);
    drive_coefs(1, 25, 1'b0);
    drive_samples(6, 50, 1, 2, 3);
    wait_idle();
    exp = '{8'd50, 8'd51, 8'd0, 8'd0, 8'd0, 8'd52, 8'd53, 8'd54, 8'd55};
    for (int j = 0; j < N_COEF - 1; j++) exp.push_back(8'd0);
    i0 = find_din(8'd50);
    mm = din_mismatch(i0, exp);
    checks++; if (i0 < 0 || mm >= 0) begin errors++; $display("FAIL und_data_in_seq: first sample at %0d, mismatch at %0d want -1", i0, mm); end
    checks++; if (mv_cyc.size() !== 30) begin errors++; $display("FAIL und_m_valid_count: got %0d want 30", mv_cyc.size()); end
    if (mv_cyc.size() >= 30) begin
      checks++; if (mv_cyc[2] - mv_cyc[1] !== 4) begin errors++; $display("FAIL und_m_valid_gap: got %0d want 4", mv_cyc[2] - mv_cyc[1]); end
      checks++; if (mv_cyc[29] - mv_cyc[0] !== 32) begin errors++; $display("FAIL und_m_valid_span: got %0d want 32", mv_cyc[29] - mv_cyc[0]); end
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_flag_set: got %0b want 1", underrun); end
    repeat (5) @(negedge clk);
    checks++; if (underrun !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL und_flag_sticky: underrun=%0b busy=%0b want 1,0", underrun, busy); end
  endtask

  task automatic test_reset_midload();
    mon_clear();
    do_start(20'd3);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_start_clears_underrun: got %0b want 0", underrun); end
    drive_coefs(1, 10, 1'b0);
    checks++; if (load_c !== 1'b1 || coef_in !== 16'd10) begin errors++; $display("FAIL mid_tenth_coef: load_c=%0b coef_in=%0d want 1,10", load_c, coef_in); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (load_c !== 1'b0 || busy !== 1'b0 || c_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: load_c=%0b busy=%0b c_ready=%0b want 0,0,0", load_c, busy, c_ready); end
    checks++; if (coef_in !== 16'd0) begin errors++; $display("FAIL mid_reset_coef: got %0h want 0", coef_in); end
    reset = 1'b1;
    @(negedge clk);
    mon_clear();
    do_start(20'd2);
    drive_coefs(1, 25, 1'b0);
    drive_samples(2, 70, 5, -1, 0);
    wait_idle();
    checks++; if (lc_vals.size() !== 25) begin errors++; $display("FAIL mid_reload_pulses: got %0d want 25", lc_vals.size()); end
    checks++; if (coef_bad() !== 0) begin errors++; $display("FAIL mid_reload_order: %0d wrong values want 0", coef_bad()); end
    checks++; if (mv_cyc.size() !== 26) begin errors++; $display("FAIL mid_m_valid_count: got %0d want 26", mv_cyc.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_end_busy: got %0b want 0", busy); end
  endtask

  task automatic test_start_busy_len0();
    int i0;
    int mm;
    logic [7:0] exp[$];
    mon_clear();
    do_start(20'd0);
    drive_coefs(1, 12, 1'b0);
    do_start(20'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy_in_load: got %0b want 1", busy); end
    drive_coefs(13, 25, 1'b0);
    drive_samples(1, 99, 0, -1, 0);
    do_start(20'd3);
    wait_idle();
    checks++; if (lc_vals.size() !== 25) begin errors++; $display("FAIL sb_load_pulses: got %0d want 25", lc_vals.size()); end
    checks++; if (coef_bad() !== 0) begin errors++; $display("FAIL sb_coef_order: %0d wrong values want 0", coef_bad()); end
    exp = '{8'd99};
    for (int j = 0; j < N_COEF - 1; j++) exp.push_back(8'd0);
    i0 = find_din(8'd99);
    mm = din_mismatch(i0, exp);
    checks++; if (i0 < 0 || mm >= 0) begin errors++; $display("FAIL sb_data_in_seq: first sample at %0d, mismatch at %0d want -1", i0, mm); end
    checks++; if (mv_cyc.size() !== 25) begin errors++; $display("FAIL sb_len0_m_valid_count: got %0d want 25", mv_cyc.size()); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL sb_underrun: got %0b want 0", underrun); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || c_ready !== 1'b0) begin errors++; $display("FAIL sb_stays_idle: busy=%0b c_ready=%0b want 0,0", busy, c_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coef_gaps();
    test_underrun();
    test_reset_midload();
    test_start_busy_len0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
